// File: rtl/prco_lmem_pkg.sv
// prco_lmem_pkg: shared data/address widths for the PRCO local memory
package prco_lmem_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  function automatic int idx_w(input int depth);
    int w;
    w = (depth > 1) ? $clog2(depth) : 1;
    return (w > ADDR_W) ? ADDR_W : w;
  endfunction
endpackage

// File: rtl/prco_lmem.sv
// prco_lmem: single-port local data memory with registered read and write echo
module prco_lmem
  import prco_lmem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_mem_we,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_dina,
  output logic [DATA_W-1:0] q_mem_douta
);
  localparam int IW = idx_w(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr_r;
  logic wr_ok, rd_ok;
  assign wr_ok = 32'(i_mem_addr) < DEPTH;
  assign rd_ok = 32'(addr_r) < DEPTH;
  // Array kept reset-free so it maps onto block/distributed RAM
  always_ff @(posedge i_clk)
    if (!i_reset && i_mem_we && wr_ok) mem[i_mem_addr[IW-1:0]] <= i_mem_dina;
  always_ff @(posedge i_clk)
    if (i_reset) begin
      addr_r      <= '0;
      q_mem_douta <= '0;
    end else begin
      addr_r      <= i_mem_addr;
      q_mem_douta <= i_mem_we ? i_mem_dina : rd_ok ? mem[addr_r[IW-1:0]] : '0;
    end
endmodule

// File: tb/tb_prco_lmem.sv
// tb_prco_lmem: directed plus random checks of prco_lmem (DEPTH=32) against a reference model
module tb_prco_lmem;
  localparam int DEPTH = 32;
  logic        i_clk = 0;
  logic        i_reset = 1;
  logic        i_mem_we = 0;
  logic [15:0] i_mem_addr = 0;
  logic [15:0] i_mem_dina = 0;
  logic [15:0] q_mem_douta;
  int vectors = 0;
  int miscompares = 0;
  logic [15:0] model_mem [DEPTH];
  int unsigned last_addr = 0;
  logic [15:0] expected;

  prco_lmem #(DEPTH) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_mem_we(i_mem_we),
    .i_mem_addr(i_mem_addr), .i_mem_dina(i_mem_dina), .q_mem_douta(q_mem_douta)
  );

  always #5 i_clk = ~i_clk;

  // Model: output shows the last transaction; a read returns the word at the
  // address presented one cycle earlier, as seen after that cycle's write.
  task automatic step(input logic r, input logic we, input logic [15:0] a,
                      input logic [15:0] d, input string tag);
    i_reset = r; i_mem_we = we; i_mem_addr = a; i_mem_dina = d;
    @(posedge i_clk);
    if (r) begin
      expected = 16'h0000;
      last_addr = 0;
    end else begin
      expected = we ? d : (last_addr < DEPTH) ? model_mem[last_addr] : 16'h0000;
      if (we && int'(a) < DEPTH) model_mem[a] = d;
      last_addr = a;
    end
    #1;
    vectors++;
    assert (q_mem_douta === expected) else begin
      miscompares++;
      $error("FAIL %s observed %h expected %h", tag, q_mem_douta, expected);
    end
  endtask

  task automatic lit(input logic [15:0] want, input string tag);
    vectors++;
    assert (q_mem_douta === want) else begin
      miscompares++;
      $error("FAIL %s observed %h expected %h", tag, q_mem_douta, want);
    end
  endtask

  initial begin
    foreach (model_mem[i]) model_mem[i] = 'x;
    step(1, 1, 3, 16'h1234, "reset0");
    step(1, 1, 3, 16'h1234, "reset1");
    lit(16'h0000, "reset_q");
    step(0, 0, 3, 0, "rd3_a");
    step(0, 0, 3, 0, "rd3_unwritten");
    step(0, 1, 0, 16'h00ab, "wr0");
    lit(16'h00ab, "echo_ab");
    step(0, 1, 1, 16'h00cd, "wr1");
    lit(16'h00cd, "echo_cd");
    step(0, 0, 0, 0, "rd_after_wr");
    lit(16'h00cd, "hold_cd");
    step(0, 0, 0, 0, "rd0");
    lit(16'h00ab, "rd_ab");
    step(0, 1, 5, 16'h5555, "wr5");
    step(0, 1, 6, 16'h6666, "wr6");
    step(0, 1, 8, 16'h0808, "wr8");
    step(0, 0, 5, 0, "pipe_a");
    step(0, 0, 6, 0, "pipe_b");
    lit(16'h5555, "pipe_5555");
    step(0, 0, 6, 0, "pipe_c");
    lit(16'h6666, "pipe_6666");
    step(0, 1, 40, 16'hbeef, "wr_oor");
    lit(16'hbeef, "echo_oor");
    step(0, 0, 40, 0, "rd_oor_a");
    step(0, 0, 40, 0, "rd_oor_b");
    lit(16'h0000, "oor_zero");
    step(0, 0, 8, 0, "rd8_a");
    step(0, 0, 8, 0, "rd8_b");
    lit(16'h0808, "no_alias");
    step(0, 0, 0, 0, "pend_rd");
    step(0, 1, 2, 16'h0022, "wr_override");
    lit(16'h0022, "override");
    for (int i = 0; i < DEPTH; i++) step(0, 1, 16'(i), 16'($urandom), "fill");
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 49) == 0), 1'($urandom), 16'($urandom_range(0, 47)),
           16'($urandom), "random");
    for (int i = 0; i < 20; i++)
      step(0, 0, 16'($urandom_range(DEPTH, 65535)), 16'($urandom), "rand_oor");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
